serial_adder: RTL
=================

# serial_adder

Parametrised bit-serial adder/subtractor built from a single full-adder slice and a registered carry. It processes a WIDTH-bit operand pair LSB first, one bit per clock, and trades latency for area against a parallel ripple adder. It sits behind a valid/ready handshake so it can drop into datapaths that already use the team's single-bit full adder as their arithmetic primitive.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..64.
- clk  input  1  the single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- in_valid  input  1  operand pair on a/b/cin/sub is valid.
- in_ready  output  1  block can accept an operand pair; high only in IDLE.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  0 = a+b+cin; 1 = a-b, computed as a+~b+1.
- out_valid  output  1  result is valid; high only in DONE.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result, low WIDTH bits.
- cout  output  1  carry out of MSB. In sub mode, 1 means no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states:
  - IDLE: in_ready=1. Accepts on in_valid and in_ready; moves to BUSY.
  - BUSY: in_ready=0, out_valid=0. Processes one bit per cycle.
  - DONE: out_valid=1; outputs held. Moves to IDLE on out_ready.
- On accept, register:
  - opA = a.
  - opB = sub ? ~b : b.
  - carry = sub ? 1 : cin.
  - count = 0.
  - sum register is cleared.
- Each BUSY cycle:
  - s = opA[0]^opB[0]^carry; c = majority(opA[0], opB[0], carry).
  - Shift opA and opB right by one.
  - Shift sum register right with s inserted at bit WIDTH-1.
  - carry = c; count = count+1.
  - When count == WIDTH-1, capture the old carry as carry-into-MSB, then go to DONE.
- In DONE:
  - cout = final carry.
  - overflow = carry-into-MSB XOR final carry.
- Arithmetic is modulo 2^WIDTH. The result must equal {cout,sum} = a + (sub ? ~b+1 : b+cin) in WIDTH+1 bits.
- in_valid and all operand inputs are ignored outside IDLE. Changes during BUSY or DONE have no effect.
- Reset values, whether from IDLE or mid-operation:
  - State IDLE; in_ready=1, out_valid=0.
  - sum=0, cout=0, overflow=0; count=0, carry=0.
  - Any in-flight operation is discarded; no result is ever presented for it.
- rst has priority over every simultaneous event, including accept and out_ready.

## Timing
- Accept happens at edge E0, on a cycle where in_valid=1 and in_ready=1. State becomes BUSY after E0.
- BUSY lasts exactly WIDTH cycles. out_valid rises after edge E_WIDTH, so latency from accept to out_valid is WIDTH cycles.
- DONE holds sum/cout/overflow stable for as long as out_ready=0.
- Handshake completes on the edge where out_valid=1 and out_ready=1. out_valid falls and in_ready rises after that edge.
- A new operand pair can be accepted no earlier than the following edge. Minimum throughput is one operation per WIDTH+2 cycles.
- in_ready and out_valid are never high in the same cycle.
- sum, cout and overflow are registered outputs. Their values are unspecified-but-stable during BUSY: they are the partial shift contents, and the consumer must qualify them with out_valid.

## Test plan
- Add wrap, WIDTH=8: a=8'hFF, b=8'h01, cin=0, sub=0 -> sum=8'h00, cout=1, overflow=0. out_valid must rise exactly 8 cycles after accept.
- Signed overflow: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, overflow=1. Also a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0, overflow=0.
- Subtract:
  - a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0, overflow=0.
  - a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, overflow=1.
  - Both cases run with cin=1 to confirm cin is ignored.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b.
  - Outputs stay unchanged; in_ready stays 0.
  - Result is consumed on the first cycle with out_ready=1; in_ready=1 on the next cycle.
- Reset mid-operation: assert rst for one cycle on the 3rd BUSY cycle.
  - Next cycle: in_ready=1, out_valid=0, sum=0.
  - A following operation a=8'h12, b=8'h34 must give sum=8'h46, cout=0.
- Exhaustive at WIDTH=4: all a, b, cin and sub combinations with random out_ready stalls. Every result must match the WIDTH+1-bit reference sum; overflow must match the signed range check.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice plus a registered carry,
// LSB first, behind valid/ready handshakes on both sides.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic             accept_s;
   logic             last_s;
   logic [WIDTH-1:0] op_a_r;
   logic [WIDTH-1:0] op_b_r;
   logic [WIDTH-1:0] sum_r;
   logic             carry_r;
   logic [CW-1:0]    count_r;
   logic             cout_r;
   logic             overflow_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             bit_sum_s;
   logic             bit_carry_s;

   function automatic logic fa_sum(input logic x, input logic y, input logic c);
      return x ^ y ^ c;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic c);
      return (x & y) | (x & c) | (y & c);
   endfunction

   // Full-adder slice on the current LSBs.
   always_comb begin
      bit_sum_s   = fa_sum(op_a_r[0], op_b_r[0], carry_r);
      bit_carry_s = fa_carry(op_a_r[0], op_b_r[0], carry_r);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and datapath strobes.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      last_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_nxt_s = BUSY;
               accept_s    = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BUSY: begin
            if (count_r == LAST_BIT) begin
               state_nxt_s = DONE;
               last_s      = 1'b1;
            end else begin
               state_nxt_s = BUSY;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Operand shifters, carry, bit counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a_r      <= '0;
         op_b_r      <= '0;
         sum_r       <= '0;
         carry_r     <= 1'b0;
         count_r     <= '0;
         cout_r      <= 1'b0;
         overflow_r  <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         in_ready_r  <= (state_nxt_s == IDLE);
         out_valid_r <= (state_nxt_s == DONE);
         if (accept_s) begin
            // Subtraction is a + ~b + 1: invert b and force the carry-in.
            op_a_r     <= a;
            op_b_r     <= sub ? ~b : b;
            carry_r    <= sub ? 1'b1 : cin;
            count_r    <= '0;
            sum_r      <= '0;
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
         end else if (state_r == BUSY) begin
            op_a_r  <= {1'b0, op_a_r[WIDTH-1:1]};
            op_b_r  <= {1'b0, op_b_r[WIDTH-1:1]};
            sum_r   <= {bit_sum_s, sum_r[WIDTH-1:1]};
            carry_r <= bit_carry_s;
            count_r <= count_r + CW'(1);
            if (last_s) begin
               // carry_r here is still the carry into the MSB.
               cout_r     <= bit_carry_s;
               overflow_r <= carry_r ^ bit_carry_s;
            end else begin
               cout_r     <= cout_r;
               overflow_r <= overflow_r;
            end
         end else begin
            op_a_r     <= op_a_r;
            op_b_r     <= op_b_r;
            sum_r      <= sum_r;
            carry_r    <= carry_r;
            count_r    <= count_r;
            cout_r     <= cout_r;
            overflow_r <= overflow_r;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign overflow  = overflow_r;

endmodule
